// File: rtl/hazard_forward_unit.sv
// Operand bypass select and load-use interlock for the integer pipeline.
// In-flight writes are tracked in a tag shift register, one entry per stage past ID.

module hazard_fwd_src #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int SW       = 2
) (
  input  logic                      i_en,
  input  logic [AW-1:0]             i_rs,
  input  logic [DEPTH:1]            i_live,
  input  logic [DEPTH:1][AW-1:0]    i_rd,
  input  logic [DEPTH:1]            i_ld,
  output logic [SW-1:0]             o_sel,
  output logic                      o_nrdy
);
  // Scan oldest to youngest so the youngest producer overwrites the result.
  always_comb begin
    o_sel  = '0;
    o_nrdy = 1'b0;
    if (i_en) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (i_live[k] && (i_rd[k] == i_rs)) begin
          o_sel  = SW'(k);
          o_nrdy = i_ld[k] && (k < LOAD_RDY);
        end
      end
    end
  end
endmodule

module hazard_forward_unit #(
  parameter  int AW       = 5,
  parameter  int NSRC     = 2,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_RDY = 2,
  parameter  int CW       = 16,
  localparam int SW       = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_rs,
  input  logic [NSRC-1:0]    id_rs_used,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_wen,
  input  logic               id_is_load,
  input  logic               ext_stall,
  input  logic               flush,
  output logic [NSRC*SW-1:0] fwd_sel,
  output logic               hz_stall,
  output logic [CW-1:0]      stall_cnt
);
  logic [DEPTH:1]          r_v;
  logic [DEPTH:1][AW-1:0]  r_rd;
  logic [DEPTH:1]          r_wen;
  logic [DEPTH:1]          r_ld;
  logic [CW-1:0]           r_cnt;

  logic [DEPTH:1]          w_live;
  logic [NSRC-1:0]         w_nrdy;
  logic                    w_stall;

  always_comb begin
    for (int k = 1; k <= DEPTH; k++)
      w_live[k] = r_v[k] && r_wen[k] && (r_rd[k] != '0);
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    logic w_en;
    assign w_en = id_valid && id_rs_used[g] && (id_rs[g*AW +: AW] != '0);
    hazard_fwd_src #(.AW(AW), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SW(SW)) u_src (
      .i_en   (w_en),
      .i_rs   (id_rs[g*AW +: AW]),
      .i_live (w_live),
      .i_rd   (r_rd),
      .i_ld   (r_ld),
      .o_sel  (fwd_sel[g*SW +: SW]),
      .o_nrdy (w_nrdy[g])
    );
  end

  assign w_stall   = (|w_nrdy) && !flush;
  assign hz_stall  = w_stall;
  assign stall_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_rd  <= '0;
      r_wen <= '0;
      r_ld  <= '0;
      r_cnt <= '0;
    end else begin
      if (ext_stall) begin
        // Frozen pipe still honours the squash of the EX slot.
        if (flush) r_v[1] <= 1'b0;
      end else begin
        for (int k = DEPTH; k >= 2; k--) begin
          r_v[k]   <= r_v[k-1];
          r_rd[k]  <= r_rd[k-1];
          r_wen[k] <= r_wen[k-1];
          r_ld[k]  <= r_ld[k-1];
        end
        r_v[1]   <= id_valid && !flush && !w_stall;
        r_rd[1]  <= id_rd;
        r_wen[1] <= id_wen;
        r_ld[1]  <= id_is_load;
      end
      if (w_stall && !ext_stall && (r_cnt != '1))
        r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule
